// File: rtl/key_echo_uart_tx.sv
// 8N1 UART transmitter that echoes each newly accepted numpad direction key.
// Optional build macro KEY_ECHO_CRLF_EN appends CR LF after every echoed key.
module key_echo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] key_prev_q, key_prev_d;
    logic       pending_q, pending_d;
    logic [7:0] pending_byte_q, pending_byte_d;
    logic       tx_q, tx_d;
    logic       busy_q, busy_d;
`ifdef KEY_ECHO_CRLF_EN
    logic [1:0] group_idx_q, group_idx_d;
`endif

    logic key_valid;
    logic valid_change;
    logic bit_end;
    logic load_key;

    assign key_valid    = (key >= 8'h31) && (key <= 8'h39);
    assign valid_change = key_valid && (key != key_prev_q);
    assign bit_end      = (cnt_q == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            bit_idx_q      <= '0;
            shift_q        <= '0;
            key_prev_q     <= '0;
            pending_q      <= 1'b0;
            pending_byte_q <= '0;
            tx_q           <= 1'b1;
            busy_q         <= 1'b0;
`ifdef KEY_ECHO_CRLF_EN
            group_idx_q    <= '0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bit_idx_q      <= bit_idx_d;
            shift_q        <= shift_d;
            key_prev_q     <= key_prev_d;
            pending_q      <= pending_d;
            pending_byte_q <= pending_byte_d;
            tx_q           <= tx_d;
            busy_q         <= busy_d;
`ifdef KEY_ECHO_CRLF_EN
            group_idx_q    <= group_idx_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        load_key  = 1'b0;
`ifdef KEY_ECHO_CRLF_EN
        group_idx_d = group_idx_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pending_q) begin
                    shift_d  = pending_byte_q;
                    load_key = 1'b1;
                    state_d  = START;
`ifdef KEY_ECHO_CRLF_EN
                    group_idx_d = 2'd0;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
`ifdef KEY_ECHO_CRLF_EN
                    // The group runs back-to-back: key, CR, LF, with no IDLE gap.
                    if (group_idx_q != 2'd2) begin
                        shift_d     = (group_idx_q == 2'd0) ? 8'h0D : 8'h0A;
                        group_idx_d = group_idx_q + 2'd1;
                        state_d     = START;
                    end else begin
                        group_idx_d = 2'd0;
                        state_d     = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A change on the same edge as the load wins over the clear, so it is not lost.
    always_comb begin
        key_prev_d     = key;
        pending_d      = pending_q;
        pending_byte_d = pending_byte_q;
        if (valid_change) begin
            pending_d      = 1'b1;
            pending_byte_d = key;
        end else if (load_key) begin
            pending_d = 1'b0;
        end
    end

    // Outputs are precomputed from next state so tx and busy come straight off flops.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != IDLE);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_key_echo_uart_tx.sv
// Directed bench for key_echo_uart_tx with CLKS_PER_BIT=4 (40-cycle frames).
// Build with KEY_ECHO_CRLF_EN defined to exercise the CR LF group instead.
module tb_key_echo_uart_tx;

    localparam int CPB = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk;
    logic       rst;
    logic [7:0] key;
    logic       tx;
    logic       busy;

    int checks = 0;
    int errors = 0;

    key_echo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk  (clk),
        .rst  (rst),
        .key  (key),
        .tx   (tx),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] key;
        bit         send;
        logic [7:0] exp;
        int         hold;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    // Waits negedge by negedge for tx low; waited is the number of negedges taken.
    task automatic wait_start(input int limit, output int waited, output bit seen);
        seen   = 1'b0;
        waited = limit + 1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (tx == 1'b0) begin
                waited = i;
                seen   = 1'b1;
                break;
            end
        end
    endtask

    // Called at the negedge of the first start-bit cycle; ends at the last stop cycle.
    task automatic recv_frame(input int cyc_a, input logic [7:0] key_a,
                              input int cyc_b, input logic [7:0] key_b,
                              output logic [7:0] data, output logic start_bit,
                              output logic stop_bit, output int busy_cnt);
        data      = 8'h00;
        start_bit = 1'b1;
        stop_bit  = 1'b0;
        busy_cnt  = 0;
        for (int c = 0; c < FRAME; c++) begin
            if (c > 0) @(negedge clk);
            if (busy) busy_cnt++;
            if (c == CPB / 2) start_bit = tx;
            if (c >= CPB + CPB / 2 && c < 9 * CPB && (c % CPB) == CPB / 2)
                data[(c - CPB) / CPB] = tx;
            if (c == 9 * CPB + CPB / 2) stop_bit = tx;
            if (c == cyc_a) key = key_a;
            if (c == cyc_b) key = key_b;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] k);
        @(negedge clk);
        key = k;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] exp_byte,
                               input int exp_wait, input int cyc_a, input logic [7:0] key_a,
                               input int cyc_b, input logic [7:0] key_b);
        int waited;
        bit seen;
        logic [7:0] data;
        logic s0, s1;
        int bc;
        wait_start(exp_wait + 4, waited, seen);
        check({name, " start seen"}, int'(seen), 1);
        check({name, " latency"}, waited, exp_wait);
        recv_frame(cyc_a, key_a, cyc_b, key_b, data, s0, s1, bc);
        check({name, " start bit"}, int'(s0), 0);
        check({name, " data"}, int'(data), int'(exp_byte));
        check({name, " stop bit"}, int'(s1), 1);
        check({name, " busy cycles"}, bc, FRAME);
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        check({name, " idle tx"}, int'(tx), 1);
        check({name, " idle busy"}, int'(busy), 0);
    endtask

    task automatic check_quiet(input string name, input int cycles);
        int activity = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (tx == 1'b0 || busy == 1'b1) activity++;
        end
        check({name, " quiet"}, activity, 0);
    endtask

    initial begin
        vecs[0] = '{key: 8'h41, send: 1'b0, exp: 8'h00, hold: 60};
        vecs[1] = '{key: 8'h34, send: 1'b1, exp: 8'h34, hold: 0};
        vecs[2] = '{key: 8'h34, send: 1'b0, exp: 8'h00, hold: 200};
        vecs[3] = '{key: 8'h35, send: 1'b1, exp: 8'h35, hold: 0};
        vecs[4] = '{key: 8'h39, send: 1'b1, exp: 8'h39, hold: 0};
        vecs[5] = '{key: 8'h30, send: 1'b0, exp: 8'h00, hold: 50};
        vecs[6] = '{key: 8'h39, send: 1'b1, exp: 8'h39, hold: 0};
        vecs[7] = '{key: 8'h3A, send: 1'b0, exp: 8'h00, hold: 50};
        vecs[8] = '{key: 8'h31, send: 1'b1, exp: 8'h31, hold: 0};
        vecs[9] = '{key: 8'h31, send: 1'b0, exp: 8'h00, hold: 50};

        rst = 1'b1;
`ifdef KEY_ECHO_CRLF_EN
        key = 8'h00;
`else
        key = 8'h34;
`endif
        repeat (3) @(negedge clk);
        check("reset tx", int'(tx), 1);
        check("reset busy", int'(busy), 0);
        rst = 1'b0;

`ifdef KEY_ECHO_CRLF_EN
        begin
            int waited;
            bit seen;
            logic [7:0] data;
            logic s0, s1;
            int bc;
            int total = 0;
            logic [7:0] exp_seq[3];
            exp_seq[0] = 8'h37;
            exp_seq[1] = 8'h0D;
            exp_seq[2] = 8'h0A;
            check_quiet("zero key after reset", 30);
            applyStimulus(8'h37);
            wait_start(8, waited, seen);
            check("crlf start seen", int'(seen), 1);
            check("crlf latency", waited, 2);
            for (int f = 0; f < 3; f++) begin
                if (f > 0) @(negedge clk);
                recv_frame(-1, 8'h00, -1, 8'h00, data, s0, s1, bc);
                check("crlf start bit", int'(s0), 0);
                check("crlf data", int'(data), int'(exp_seq[f]));
                check("crlf stop bit", int'(s1), 1);
                total += bc;
            end
            check("crlf busy cycles", total, 3 * FRAME);
            check_idle("crlf");
            check_quiet("crlf after group", 60);
        end
`else
        checkOutput("reset echo 0x34", 8'h34, 2, -1, 8'h00, -1, 8'h00);
        check_idle("reset echo");
        check_quiet("reset echo no repeat", 40);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].key);
            if (vecs[i].send) begin
                checkOutput($sformatf("vec%0d", i), vecs[i].exp, 2, -1, 8'h00, -1, 8'h00);
                check_idle($sformatf("vec%0d", i));
            end else begin
                check_quiet($sformatf("vec%0d", i), vecs[i].hold);
            end
        end

        // Overwrite while busy: only the latest key survives.
        applyStimulus(8'h38);
        checkOutput("overwrite first", 8'h38, 2, 10, 8'h36, 20, 8'h32);
        check_idle("overwrite gap");
        checkOutput("overwrite latest", 8'h32, 1, -1, 8'h00, -1, 8'h00);
        check_idle("overwrite");
        check_quiet("overwrite nothing lost extra", 60);

        // Change in the last stop cycle is sent after a single idle cycle.
        applyStimulus(8'h35);
        checkOutput("stop edge first", 8'h35, 2, FRAME - 1, 8'h39, -1, 8'h00);
        check_idle("stop edge gap");
        checkOutput("stop edge second", 8'h39, 1, -1, 8'h00, -1, 8'h00);
        check_idle("stop edge");

        // Reset in the middle of data bit 3.
        begin
            int waited;
            bit seen;
            applyStimulus(8'h36);
            wait_start(8, waited, seen);
            check("midreset start seen", int'(seen), 1);
            repeat (4 * CPB + 1) @(negedge clk);
            check("midreset busy before", int'(busy), 1);
            rst = 1'b1;
            @(negedge clk);
            check("midreset tx", int'(tx), 1);
            check("midreset busy", int'(busy), 0);
            key = 8'h00;
            @(negedge clk);
            rst = 1'b0;
            check_quiet("midreset no residual", 80);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_echo_uart_tx.md
# key_echo_uart_tx

Serial transmitter that echoes the snake's latched direction key back to the host terminal over the Basys3 USB-UART (8N1, LSB first). It sits downstream of the keyboard driver's `key` output and drives the FPGA `RsTx` pin. When a new valid numpad code arrives, the block queues it as a single pending byte and serialises it, giving the player visible confirmation of each accepted direction change.

## Interface
- `CLKS_PER_BIT`, 868: clk cycles per UART bit (100 MHz / 115200); legal range 2..65535.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high; clock `clk`.
- `key`  in  8  latched direction code from the keyboard driver (ASCII `0x31`..`0x39`).
- `tx`  out  1  UART serial line; idles high.
- `busy`  out  1  high while any frame is on the line (from start bit through stop bit).

## Operation
- **Change detect:** `key_prev` is registered every cycle.
  - Valid change: `key != key_prev` and `key` is in `0x31`..`0x39`. This sets `pending`=1 and loads `pending_byte`=`key`.
  - Invalid codes update `key_prev` but never set `pending`.
- **Pending buffer:** depth 1.
  - A new valid change while `pending`=1 overwrites `pending_byte` (latest wins).
  - `pending` clears on the cycle its byte is loaded into the shifter.
  - A change on the same edge as the load is kept as the new pending byte, not lost.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: `tx`=1, `busy`=0. If `pending`=1, load the shifter and go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with `bit_idx`=0.
  - DATA: `tx`=`shift[0]` for `CLKS_PER_BIT` cycles per bit, shifting right after each bit. After bit 7 go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. Then go to START if another group character remains (see Configuration), otherwise to IDLE.
- **Baud counter:**
  - Width `$clog2(CLKS_PER_BIT)`; counts 0..`CLKS_PER_BIT`-1 and wraps to 0 on each bit boundary.
  - Reset to 0 on every state entry.
- **Reset** (any time, including mid-frame) forces:
  - `tx`=1, `busy`=0, state IDLE;
  - `pending`=0, `key_prev`=0, counters 0.
- Because `key_prev` resets to 0, the keyboard driver's post-reset default (`0x34`) is echoed once after reset.

## Timing
- Latency from a `key` change to the start bit:
  - the change is visible before edge E0;
  - `pending` is set at E0;
  - the FSM enters START at E1, so `tx`=0 is first driven in the cycle after E1.
- Frame length: exactly 10×`CLKS_PER_BIT` cycles. `busy` is high for that whole span.
- There is at least one IDLE cycle between groups. Characters within one group are sent back-to-back with no IDLE cycle between them.
- A valid change during the final STOP cycle is captured. It is sent after one IDLE cycle.
- Output is glitch-free: `tx` is driven directly from a flop.

## Configuration
- Macro: `KEY_ECHO_CRLF_EN`.
- **Defined:** each group is three frames: the key byte, then `0x0D`, then `0x0A`.
  - `busy` stays high across all 30×`CLKS_PER_BIT` cycles.
  - A sub-counter (0..2) selects the byte loaded on each STOP→START transition.
  - `pending` may be set during the group; it is served after the group completes.
- **Undefined:** each group is a single frame carrying the key byte only, and no sub-counter is synthesised.

## Test plan
Benches use `CLKS_PER_BIT`=4.
- **Reset release:** release `rst` with `key`=`0x34` held.
  - `tx` low 2 cycles after release.
  - Decoded bits (LSB first): 0,0,1,0,1,1,0,0, then stop=1.
  - `busy` high for 40 cycles.
  - `tx` high and `busy`=0 afterwards.
- **Invalid and repeated codes:** change `key` to `0x41`, then back to `0x34`.
  - `0x41` sends nothing.
  - The return to `0x34` sends `0x34`, because it differs from `key_prev`=`0x41`.
  - Holding `key` constant for 200 cycles sends nothing further.
- **Overwrite while busy:** during a `0x38` frame, change `key` to `0x36` and then to `0x32`.
  - After the `0x38` frame and 1 IDLE cycle, only `0x32` is sent.
- **Change in final stop cycle:** change `key` to `0x39` in the last STOP cycle.
  - `0x39` starts after exactly 1 IDLE cycle; no byte is lost.
- **Reset mid-frame:** assert `rst` during DATA bit 3.
  - Next cycle: `tx`=1, `busy`=0.
  - No residual frame after release unless `key`≠0.
- **With `KEY_ECHO_CRLF_EN`:** `key`→`0x37`.
  - Sends `0x37`, `0x0D`, `0x0A` back-to-back.
  - `busy` high for 120 cycles.
